control_sequencer: RTL and testbench

- Hardwired control unit that drives the datapath's control strobes, one control step per clock.
- Runs the fixed fetch sequence (T0–T2), decodes ir[31:27], then issues the instruction's execute steps (T3–T7).
- Sits beside the datapath: consumes its IR and branch-condition flag, produces every strobe the datapath accepts.

---
 rtl/cu_pkg.sv | 73 +++++++
 rtl/control_sequencer_if.sv | 39 +++
 rtl/cu_decode.sv | 34 +++
 rtl/control_sequencer.sv | 169 ++++++++++++++++
 tb/tb_control_sequencer.sv | 193 +++++++++++++++++++
 5 files changed

// File: rtl/cu_pkg.sv
// Shared definitions for the hardwired control unit.
//   - opcode values (ir[31:27])
//   - ALU operation codes, also used by the datapath ALU
//   - state encoding (RESET, T0..T7, HALT)
//   - instruction-class one-hot and control-strobe bundle
package cu_pkg;

  localparam int CU_IR_W = 32;
  localparam int CU_OP_W = 5;

  // Opcodes
  localparam logic [4:0] OP_LD   = 5'd0,  OP_LDI  = 5'd1,  OP_ST   = 5'd2,
                         OP_ADD  = 5'd3,  OP_SUB  = 5'd4,  OP_AND  = 5'd5,
                         OP_OR   = 5'd6,  OP_SHR  = 5'd7,  OP_SHL  = 5'd8,
                         OP_ROR  = 5'd9,  OP_ROL  = 5'd10, OP_ADDI = 5'd11,
                         OP_ANDI = 5'd12, OP_ORI  = 5'd13, OP_MUL  = 5'd14,
                         OP_DIV  = 5'd15, OP_NEG  = 5'd16, OP_NOT  = 5'd17,
                         OP_BR   = 5'd18, OP_JR   = 5'd19, OP_IN   = 5'd20,
                         OP_OUT  = 5'd21, OP_MFHI = 5'd22, OP_MFLO = 5'd23,
                         OP_NOP  = 5'd24, OP_HALT = 5'd25;

  // ALU operation codes
  localparam logic [3:0] ALU_AND = 4'd0, ALU_OR  = 4'd1, ALU_ADD = 4'd2,
                         ALU_SUB = 4'd3, ALU_SHR = 4'd4, ALU_SHL = 4'd5,
                         ALU_ROR = 4'd6, ALU_ROL = 4'd7, ALU_MUL = 4'd8,
                         ALU_DIV = 4'd9, ALU_NEG = 4'd10, ALU_NOT = 4'd11;

  // State encoding
  localparam logic [3:0] ST_RESET = 4'd0, ST_T0 = 4'd1, ST_T1 = 4'd2,
                         ST_T2    = 4'd3, ST_T3 = 4'd4, ST_T4 = 4'd5,
                         ST_T5    = 4'd6, ST_T6 = 4'd7, ST_T7 = 4'd8,
                         ST_HALT  = 4'd9;

  typedef enum logic [3:0] {
    RESET = ST_RESET, T0 = ST_T0, T1 = ST_T1, T2 = ST_T2, T3 = ST_T3,
    T4 = ST_T4, T5 = ST_T5, T6 = ST_T6, T7 = ST_T7, HALT = ST_HALT
  } state_t;

  // Instruction class, exactly one bit set
  typedef struct packed {
    logic regalu, imm, ld, ldi, st, muldiv, unary, br;
    logic jr, inp, outp, mfhi, mflo, halt, nop;
  } cls_t;

  // Every strobe the sequencer drives
  typedef struct packed {
    logic       run;
    logic [3:0] alu_op;
    logic pc_out, z_high_out, z_low_out, mdr_out, hi_out, lo_out, inport_out, c_out;
    logic gra, grb, grc, r_in, r_out, ba_out;
    logic pc_in, ir_in, mar_in, mdr_in, y_in, z_in, hi_in, lo_in, outport_in, con_in;
    logic inc_pc, read, write;
  } ctrl_t;

  // ALU code for opcodes that carry one; everything else defaults to AND.
  function automatic logic [3:0] op_alu(input logic [4:0] op);
    case (op)
      OP_ADD, OP_ADDI: op_alu = ALU_ADD;
      OP_SUB:          op_alu = ALU_SUB;
      OP_OR,  OP_ORI:  op_alu = ALU_OR;
      OP_SHR:          op_alu = ALU_SHR;
      OP_SHL:          op_alu = ALU_SHL;
      OP_ROR:          op_alu = ALU_ROR;
      OP_ROL:          op_alu = ALU_ROL;
      OP_MUL:          op_alu = ALU_MUL;
      OP_DIV:          op_alu = ALU_DIV;
      OP_NEG:          op_alu = ALU_NEG;
      OP_NOT:          op_alu = ALU_NOT;
      default:         op_alu = ALU_AND;
    endcase
  endfunction

endpackage

// File: rtl/control_sequencer_if.sv
// Sequencer <-> datapath bundle.
//   master: control unit (consumes ir/con_ff[/mem_ready], drives strobes)
//   slave : datapath
// CU_MEM_WAIT_EN adds mem_ready (memory handshake for read/write steps).
interface control_sequencer_if #(parameter int IR_W = 32);
  logic [IR_W-1:0] ir;
  logic            con_ff;
`ifdef CU_MEM_WAIT_EN
  logic            mem_ready;
`endif
  logic pc_out, z_high_out, z_low_out, mdr_out, hi_out, lo_out, inport_out, c_out;
  logic gra, grb, grc, r_in, r_out, ba_out;
  logic pc_in, ir_in, mar_in, mdr_in, y_in, z_in, hi_in, lo_in, outport_in, con_in;
  logic inc_pc, read, write;
  logic [3:0] alu_op;
  logic run;

  modport master (
    input  ir, con_ff,
`ifdef CU_MEM_WAIT_EN
    input  mem_ready,
`endif
    output pc_out, z_high_out, z_low_out, mdr_out, hi_out, lo_out, inport_out, c_out,
    output gra, grb, grc, r_in, r_out, ba_out,
    output pc_in, ir_in, mar_in, mdr_in, y_in, z_in, hi_in, lo_in, outport_in, con_in,
    output inc_pc, read, write, alu_op, run
  );

  modport slave (
    output ir, con_ff,
`ifdef CU_MEM_WAIT_EN
    output mem_ready,
`endif
    input  pc_out, z_high_out, z_low_out, mdr_out, hi_out, lo_out, inport_out, c_out,
    input  gra, grb, grc, r_in, r_out, ba_out,
    input  pc_in, ir_in, mar_in, mdr_in, y_in, z_in, hi_in, lo_in, outport_in, con_in,
    input  inc_pc, read, write, alu_op, run
  );
endinterface

// File: rtl/cu_decode.sv
// Opcode -> instruction class (one-hot) plus the ALU code the class uses.
//   opcode  in : ir[31:27]
//   cls     out: one-hot class; unused opcodes 26-31 fall into nop
//   alu_sel out: ALU code for reg-ALU/immediate/muldiv/unary ops
module cu_decode import cu_pkg::*; (
  input  logic [CU_OP_W-1:0] opcode,
  output cls_t               cls,
  output logic [3:0]         alu_sel
);
  always_comb begin
    cls = '0;
    case (opcode)
      OP_LD:   cls.ld   = 1'b1;
      OP_LDI:  cls.ldi  = 1'b1;
      OP_ST:   cls.st   = 1'b1;
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR, OP_SHL, OP_ROR, OP_ROL:
               cls.regalu = 1'b1;
      OP_ADDI, OP_ANDI, OP_ORI:
               cls.imm  = 1'b1;
      OP_MUL, OP_DIV: cls.muldiv = 1'b1;
      OP_NEG, OP_NOT: cls.unary  = 1'b1;
      OP_BR:   cls.br   = 1'b1;
      OP_JR:   cls.jr   = 1'b1;
      OP_IN:   cls.inp  = 1'b1;
      OP_OUT:  cls.outp = 1'b1;
      OP_MFHI: cls.mfhi = 1'b1;
      OP_MFLO: cls.mflo = 1'b1;
      OP_HALT: cls.halt = 1'b1;
      default: cls.nop  = 1'b1;
    endcase
  end

  assign alu_sel = op_alu(opcode);
endmodule

// File: rtl/control_sequencer.sv
// Hardwired control sequencer: fetch T0-T2, decode ir[31:27], execute T3-T7.
// Outputs are a function of the state register (plus the held IR class and
// con_ff for the conditional branch load).
//   clk      in : rising-edge clock
//   reset_n  in : synchronous active-low reset
//   bus         : control_sequencer_if.master (ir, con_ff in; strobes out)
// Optional macro CU_MEM_WAIT_EN: read/write states stall until mem_ready=1.
module control_sequencer import cu_pkg::*; #(
  parameter int IR_W = CU_IR_W,
  parameter int OP_W = CU_OP_W
) (
  input  logic                  clk,
  input  logic                  reset_n,
  control_sequencer_if.master   bus
);
  state_t     state, nxt;
  cls_t       cls;
  logic [3:0] alu_sel;
  ctrl_t      c;
  logic       mem_ok;

`ifdef CU_MEM_WAIT_EN
  assign mem_ok = bus.mem_ready;
`else
  assign mem_ok = 1'b1;
`endif

  cu_decode u_dec (
    .opcode  (bus.ir[IR_W-1 -: OP_W]),
    .cls     (cls),
    .alu_sel (alu_sel)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) state <= RESET;
    else          state <= nxt;
  end

  always_comb begin
    nxt   = state;
    c     = '0;
    c.run = 1'b1;
    case (state)
      RESET: begin
        c.run = 1'b0;
        nxt   = T0;
      end
      T0: begin
        c.pc_out = 1'b1; c.mar_in = 1'b1; c.inc_pc = 1'b1; c.z_in = 1'b1;
        c.alu_op = ALU_ADD;
        nxt = T1;
      end
      T1: begin
        c.z_low_out = 1'b1; c.pc_in = 1'b1; c.read = 1'b1; c.mdr_in = 1'b1;
        if (mem_ok) nxt = T2;
      end
      T2: begin
        c.mdr_out = 1'b1; c.ir_in = 1'b1;
        nxt = T3;
      end
      T3: begin
        c.gra        = cls.muldiv | cls.jr | cls.inp | cls.outp | cls.mfhi | cls.mflo;
        c.grb        = cls.regalu | cls.imm | cls.ld | cls.ldi | cls.st | cls.unary | cls.br;
        c.r_out      = cls.regalu | cls.imm | cls.muldiv | cls.unary | cls.br | cls.jr | cls.outp;
        c.ba_out     = cls.ld | cls.ldi | cls.st;
        c.y_in       = cls.regalu | cls.imm | cls.ld | cls.ldi | cls.st | cls.muldiv;
        c.z_in       = cls.unary;
        c.alu_op     = cls.unary ? alu_sel : ALU_AND;
        c.con_in     = cls.br;
        c.pc_in      = cls.jr;
        c.r_in       = cls.inp | cls.mfhi | cls.mflo;
        c.inport_out = cls.inp;
        c.outport_in = cls.outp;
        c.hi_out     = cls.mfhi;
        c.lo_out     = cls.mflo;
        if (cls.halt)
          nxt = HALT;
        else if (cls.jr | cls.inp | cls.outp | cls.mfhi | cls.mflo | cls.nop)
          nxt = T0;
        else
          nxt = T4;
      end
      T4: begin
        c.grc       = cls.regalu;
        c.grb       = cls.muldiv;
        c.r_out     = cls.regalu | cls.muldiv;
        c.c_out     = cls.imm | cls.ld | cls.ldi | cls.st;
        c.z_in      = cls.regalu | cls.imm | cls.ld | cls.ldi | cls.st | cls.muldiv;
        c.alu_op    = (cls.regalu | cls.imm | cls.muldiv) ? alu_sel :
                      (cls.ld | cls.ldi | cls.st)         ? ALU_ADD : ALU_AND;
        c.z_low_out = cls.unary;
        c.gra       = cls.unary;
        c.r_in      = cls.unary;
        c.pc_out    = cls.br;
        c.y_in      = cls.br;
        nxt = cls.unary ? T0 : T5;
      end
      T5: begin
        c.z_low_out = cls.regalu | cls.imm | cls.ldi | cls.ld | cls.st | cls.muldiv;
        c.gra       = cls.regalu | cls.imm | cls.ldi;
        c.r_in      = cls.regalu | cls.imm | cls.ldi;
        c.mar_in    = cls.ld | cls.st;
        c.lo_in     = cls.muldiv;
        c.c_out     = cls.br;
        c.z_in      = cls.br;
        c.alu_op    = cls.br ? ALU_ADD : ALU_AND;
        nxt = (cls.regalu | cls.imm | cls.ldi) ? T0 : T6;
      end
      T6: begin
        c.read       = cls.ld;
        c.mdr_in     = cls.ld | cls.st;
        c.gra        = cls.st;
        c.r_out      = cls.st;
        c.z_high_out = cls.muldiv;
        c.hi_in      = cls.muldiv;
        c.z_low_out  = cls.br;
        c.pc_in      = cls.br & bus.con_ff;
        if (cls.ld)      nxt = mem_ok ? T7 : T6;
        else if (cls.st) nxt = T7;
        else             nxt = T0;
      end
      T7: begin
        c.mdr_out = cls.ld;
        c.gra     = cls.ld;
        c.r_in    = cls.ld;
        c.write   = cls.st;
        nxt = (cls.st & ~mem_ok) ? T7 : T0;
      end
      HALT: begin
        c.run = 1'b0;
        nxt   = HALT;
      end
      default: begin
        c.run = 1'b0;
        nxt   = RESET;
      end
    endcase
  end

  assign bus.run        = c.run;
  assign bus.alu_op     = c.alu_op;
  assign bus.pc_out     = c.pc_out;
  assign bus.z_high_out = c.z_high_out;
  assign bus.z_low_out  = c.z_low_out;
  assign bus.mdr_out    = c.mdr_out;
  assign bus.hi_out     = c.hi_out;
  assign bus.lo_out     = c.lo_out;
  assign bus.inport_out = c.inport_out;
  assign bus.c_out      = c.c_out;
  assign bus.gra        = c.gra;
  assign bus.grb        = c.grb;
  assign bus.grc        = c.grc;
  assign bus.r_in       = c.r_in;
  assign bus.r_out      = c.r_out;
  assign bus.ba_out     = c.ba_out;
  assign bus.pc_in      = c.pc_in;
  assign bus.ir_in      = c.ir_in;
  assign bus.mar_in     = c.mar_in;
  assign bus.mdr_in     = c.mdr_in;
  assign bus.y_in       = c.y_in;
  assign bus.z_in       = c.z_in;
  assign bus.hi_in      = c.hi_in;
  assign bus.lo_in      = c.lo_in;
  assign bus.outport_in = c.outport_in;
  assign bus.con_in     = c.con_in;
  assign bus.inc_pc     = c.inc_pc;
  assign bus.read       = c.read;
  assign bus.write      = c.write;
endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer: reset, fetch, several instruction
// classes, branch taken/not taken, halt, reset mid-instruction and (with
// CU_MEM_WAIT_EN) the memory wait in T1.
module tb_control_sequencer;
  logic clk = 1'b0;
  logic reset_n;
  int   n_chk = 0;
  int   n_err = 0;

  control_sequencer_if bus ();
  control_sequencer dut (.clk(clk), .reset_n(reset_n), .bus(bus.master));

  always #5 clk = ~clk;

  // Observed control word: {run, alu_op, 27 strobes}
  wire [31:0] obs = {bus.run, bus.alu_op, bus.write, bus.read, bus.inc_pc,
                     bus.con_in, bus.outport_in, bus.lo_in, bus.hi_in, bus.z_in,
                     bus.y_in, bus.mdr_in, bus.mar_in, bus.ir_in, bus.pc_in,
                     bus.ba_out, bus.r_out, bus.r_in, bus.grc, bus.grb, bus.gra,
                     bus.c_out, bus.inport_out, bus.lo_out, bus.hi_out,
                     bus.mdr_out, bus.z_low_out, bus.z_high_out, bus.pc_out};

  localparam logic [31:0]
    PC_OUT = 32'h1 << 0,  Z_HIGH = 32'h1 << 1,  Z_LOW  = 32'h1 << 2,
    MDR_OUT= 32'h1 << 3,  HI_OUT = 32'h1 << 4,  LO_OUT = 32'h1 << 5,
    INP_OUT= 32'h1 << 6,  C_OUT  = 32'h1 << 7,  GRA    = 32'h1 << 8,
    GRB    = 32'h1 << 9,  GRC    = 32'h1 << 10, R_IN   = 32'h1 << 11,
    R_OUT  = 32'h1 << 12, BA_OUT = 32'h1 << 13, PC_IN  = 32'h1 << 14,
    IR_IN  = 32'h1 << 15, MAR_IN = 32'h1 << 16, MDR_IN = 32'h1 << 17,
    Y_IN   = 32'h1 << 18, Z_IN   = 32'h1 << 19, HI_IN  = 32'h1 << 20,
    LO_IN  = 32'h1 << 21, OUTP_IN= 32'h1 << 22, CON_IN = 32'h1 << 23,
    INC_PC = 32'h1 << 24, READ   = 32'h1 << 25, WRITE  = 32'h1 << 26,
    RUN    = 32'h1 << 31;

  function automatic logic [31:0] alu(input int v);
    return 32'(v) << 27;
  endfunction

  localparam logic [31:0] E_T0 = RUN | PC_OUT | MAR_IN | INC_PC | Z_IN | (32'd2 << 27);
  localparam logic [31:0] E_T1 = RUN | Z_LOW | PC_IN | READ | MDR_IN;
  localparam logic [31:0] E_T2 = RUN | MDR_OUT | IR_IN;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Starts in T0: checks fetch, n execute steps, then the return to T0.
  task automatic run_ins(input string tag, input logic [31:0] irv,
                         input logic [31:0] ex [5], input int n);
    bus.ir = irv;
    chk({tag, "_t0"}, obs, E_T0); step();
    chk({tag, "_t1"}, obs, E_T1); step();
    chk({tag, "_t2"}, obs, E_T2); step();
    for (int i = 0; i < n; i++) begin
      chk($sformatf("%s_t%0d", tag, i + 3), obs, ex[i]);
      step();
    end
    chk({tag, "_end"}, obs, E_T0);
  endtask

  initial begin
    logic [31:0] ex [5];
    bus.ir     = 32'h0;
    bus.con_ff = 1'b0;
`ifdef CU_MEM_WAIT_EN
    bus.mem_ready = 1'b1;
`endif
    reset_n = 1'b0;
    step(); chk("rst0", obs, 32'h0);
    step(); chk("rst1", obs, 32'h0);
    reset_n = 1'b1;
    step();

    // in R1: 4 cycles
    ex = '{RUN | GRA | R_IN | INP_OUT, 0, 0, 0, 0};
    run_ins("in", 32'hA0800000, ex, 1);

    // add R3,R1,R2
    ex = '{RUN | GRB | R_OUT | Y_IN, RUN | GRC | R_OUT | Z_IN | alu(2),
           RUN | Z_LOW | GRA | R_IN, 0, 0};
    run_ins("add", 32'h19890000, ex, 3);

    // shr: alu 4
    ex = '{RUN | GRB | R_OUT | Y_IN, RUN | GRC | R_OUT | Z_IN | alu(4),
           RUN | Z_LOW | GRA | R_IN, 0, 0};
    run_ins("shr", 32'h38000000, ex, 3);

    // br, not taken then taken
    bus.con_ff = 1'b0;
    ex = '{RUN | GRB | R_OUT | CON_IN, RUN | PC_OUT | Y_IN,
           RUN | C_OUT | Z_IN | alu(2), RUN | Z_LOW, 0};
    run_ins("br_nt", 32'h90000000, ex, 4);
    bus.con_ff = 1'b1;
    ex[3] = RUN | Z_LOW | PC_IN;
    run_ins("br_tk", 32'h90000000, ex, 4);
    bus.con_ff = 1'b0;

    // st
    ex = '{RUN | GRB | BA_OUT | Y_IN, RUN | C_OUT | Z_IN | alu(2),
           RUN | Z_LOW | MAR_IN, RUN | GRA | R_OUT | MDR_IN, RUN | WRITE};
    run_ins("st", 32'h10000000, ex, 5);

    // ld
    ex = '{RUN | GRB | BA_OUT | Y_IN, RUN | C_OUT | Z_IN | alu(2),
           RUN | Z_LOW | MAR_IN, RUN | READ | MDR_IN, RUN | MDR_OUT | GRA | R_IN};
    run_ins("ld", 32'h00000000, ex, 5);

    // ldi
    ex = '{RUN | GRB | BA_OUT | Y_IN, RUN | C_OUT | Z_IN | alu(2),
           RUN | Z_LOW | GRA | R_IN, 0, 0};
    run_ins("ldi", 32'h08000000, ex, 3);

    // mul
    ex = '{RUN | GRA | R_OUT | Y_IN, RUN | GRB | R_OUT | Z_IN | alu(8),
           RUN | Z_LOW | LO_IN, RUN | Z_HIGH | HI_IN, 0};
    run_ins("mul", 32'h70000000, ex, 4);

    // ori: alu 1
    ex = '{RUN | GRB | R_OUT | Y_IN, RUN | C_OUT | Z_IN | alu(1),
           RUN | Z_LOW | GRA | R_IN, 0, 0};
    run_ins("ori", 32'h68000000, ex, 3);

    // neg
    ex = '{RUN | GRB | R_OUT | Z_IN | alu(10), RUN | Z_LOW | GRA | R_IN, 0, 0, 0};
    run_ins("neg", 32'h80000000, ex, 2);

    // jr, out, mfhi, mflo
    ex = '{RUN | GRA | R_OUT | PC_IN, 0, 0, 0, 0};
    run_ins("jr", 32'h98000000, ex, 1);
    ex = '{RUN | GRA | R_OUT | OUTP_IN, 0, 0, 0, 0};
    run_ins("out", 32'hA8000000, ex, 1);
    ex = '{RUN | GRA | R_IN | HI_OUT, 0, 0, 0, 0};
    run_ins("mfhi", 32'hB0000000, ex, 1);
    ex = '{RUN | GRA | R_IN | LO_OUT, 0, 0, 0, 0};
    run_ins("mflo", 32'hB8000000, ex, 1);

    // opcode 27 behaves as nop
    ex = '{RUN, 0, 0, 0, 0};
    run_ins("op27", 32'hD8000000, ex, 1);

`ifdef CU_MEM_WAIT_EN
    // T1 stalls while mem_ready=0
    bus.ir = 32'hC0000000;  // nop
    bus.mem_ready = 1'b0;
    step();
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("wait_t1_%0d", k), obs, E_T1);
      step();
    end
    chk("wait_t1_3", obs, E_T1);
    bus.mem_ready = 1'b1;
    step();
    chk("wait_t2", obs, E_T2);
    step(); step();
    chk("wait_end", obs, E_T0);
`endif

    // reset during ld T5
    bus.ir = 32'h00000000;
    for (int k = 0; k < 5; k++) step();
    chk("ld_t5", obs, RUN | Z_LOW | MAR_IN);
    reset_n = 1'b0;
    step(); chk("mid_rst", obs, 32'h0);
    reset_n = 1'b1;
    step(); chk("mid_rst_t0", obs, E_T0);

    // halt: T3 then run low for 20 clocks
    ex = '{RUN, 0, 0, 0, 0};
    bus.ir = 32'hC8000000;
    step(); step(); step();
    chk("halt_t3", obs, RUN);
    for (int k = 0; k < 20; k++) begin
      step();
      chk($sformatf("halt_%0d", k), obs, 32'h0);
    end
    reset_n = 1'b0;
    step(); chk("halt_rst", obs, 32'h0);
    reset_n = 1'b1;
    step(); chk("halt_rst_t0", obs, E_T0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
